tx_sym_scheduler: RTL and testbench

TX_SYM_SCHEDULER -- requirements
Module: tx_sym_scheduler

---
 rtl/tx_sym_scheduler.sv | 165 ++++++++++++++++
 tb/tb_tx_sym_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tx_sym_scheduler.sv
// TX symbol scheduler: derives the OFDM symbol count and pad bits for a packet, then offers its symbols one by one.
// Build option: define TX_SCHED_HT_EN to accept HT rate codes; otherwise any HT code raises rate_err.
module tx_sym_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [7:0]  pkt_rate,
  input  logic [15:0] pkt_len,
  input  logic        sym_ready,
  output logic        sym_valid,
  output logic [15:0] sym_idx,
  output logic        last_sym,
  output logic [15:0] n_sym,
  output logic [8:0]  n_pad,
  output logic        busy,
  output logic        done,
  output logic        rate_err
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [8:0]  dbps_reg, dbps_next;
  logic        bad_reg, bad_next;
  logic [20:0] target_reg, target_next;
  logic [21:0] acc_reg, acc_next;
  logic [15:0] n_sym_reg, n_sym_next;
  logic [15:0] sym_idx_reg, sym_idx_next;
  logic [8:0]  n_pad_reg, n_pad_next;

  logic [8:0]  lut_dbps;
  logic        lut_ok;
  logic        len_bad;
  logic [21:0] acc_sum;
  logic [21:0] target_ext;
  logic        is_last;
  logic        unused_rate_bits;

  // Bits [6:4] of the rate byte carry no meaning for symbol scheduling.
  assign unused_rate_bits = ^pkt_rate[6:4];

  always_comb begin
    lut_dbps = '0;
    lut_ok   = 1'b0;
    if (!pkt_rate[7]) begin
      lut_ok = 1'b1;
      case (pkt_rate[3:0])
        4'b1011: lut_dbps = 9'd24;
        4'b1111: lut_dbps = 9'd36;
        4'b1010: lut_dbps = 9'd48;
        4'b1110: lut_dbps = 9'd72;
        4'b1001: lut_dbps = 9'd96;
        4'b1101: lut_dbps = 9'd144;
        4'b1000: lut_dbps = 9'd192;
        4'b1100: lut_dbps = 9'd216;
        default: lut_ok   = 1'b0;
      endcase
    end
`ifdef TX_SCHED_HT_EN
    else if (!pkt_rate[3]) begin
      lut_ok = 1'b1;
      case (pkt_rate[2:0])
        3'd0: lut_dbps = 9'd26;
        3'd1: lut_dbps = 9'd52;
        3'd2: lut_dbps = 9'd78;
        3'd3: lut_dbps = 9'd104;
        3'd4: lut_dbps = 9'd156;
        3'd5: lut_dbps = 9'd208;
        3'd6: lut_dbps = 9'd234;
        3'd7: lut_dbps = 9'd260;
      endcase
    end
`endif
  end

  // Legacy PSDUs are limited to 4095 bytes.
  assign len_bad    = !pkt_rate[7] && (pkt_len[15:12] != 4'd0);
  assign acc_sum    = acc_reg + {13'd0, dbps_reg};
  assign target_ext = {1'b0, target_reg};
  assign is_last    = (sym_idx_reg == n_sym_reg - 16'd1);

  always_comb begin
    state_next   = state_reg;
    dbps_next    = dbps_reg;
    bad_next     = bad_reg;
    target_next  = target_reg;
    acc_next     = acc_reg;
    n_sym_next   = n_sym_reg;
    sym_idx_next = sym_idx_reg;
    n_pad_next   = n_pad_reg;
    done         = 1'b0;
    rate_err     = 1'b0;
    if (enable) begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            dbps_next   = lut_dbps;
            bad_next    = !lut_ok || len_bad;
            target_next = {2'b00, pkt_len, 3'b000} + 21'd22;
            acc_next    = '0;
            n_sym_next  = '0;
            state_next  = S_CALC;
          end
        end
        S_CALC: begin
          if (bad_reg) begin
            rate_err   = 1'b1;
            state_next = S_IDLE;
          end else begin
            // One N_DBPS step per cycle: the loop exit yields ceil(target/N_DBPS).
            acc_next   = acc_sum;
            n_sym_next = n_sym_reg + 16'd1;
            if (acc_sum >= target_ext) begin
              n_pad_next   = 9'(acc_sum - target_ext);
              sym_idx_next = '0;
              state_next   = S_SEND;
            end
          end
        end
        S_SEND: begin
          if (sym_ready) begin
            sym_idx_next = sym_idx_reg + 16'd1;
            if (is_last) state_next = S_DONE;
          end
        end
        S_DONE: begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      dbps_reg    <= '0;
      bad_reg     <= 1'b0;
      target_reg  <= '0;
      acc_reg     <= '0;
      n_sym_reg   <= '0;
      sym_idx_reg <= '0;
      n_pad_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      dbps_reg    <= dbps_next;
      bad_reg     <= bad_next;
      target_reg  <= target_next;
      acc_reg     <= acc_next;
      n_sym_reg   <= n_sym_next;
      sym_idx_reg <= sym_idx_next;
      n_pad_reg   <= n_pad_next;
    end
  end

  assign sym_valid = (state_reg == S_SEND);
  assign last_sym  = sym_valid && is_last;
  assign sym_idx   = sym_idx_reg;
  assign n_sym     = n_sym_reg;
  assign n_pad     = n_pad_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_tx_sym_scheduler.sv
// Directed testbench for tx_sym_scheduler: per-packet runs checked against hand-computed symbol/pad counts.
module tb_tx_sym_scheduler;

  logic        clock = 1'b0;
  logic        reset, enable, start, sym_ready;
  logic [7:0]  pkt_rate;
  logic [15:0] pkt_len;
  logic        sym_valid, last_sym, busy, done, rate_err;
  logic [15:0] sym_idx, n_sym;
  logic [8:0]  n_pad;

  int tests = 0;
  int fails = 0;

  tx_sym_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .pkt_rate(pkt_rate), .pkt_len(pkt_len), .sym_ready(sym_ready),
    .sym_valid(sym_valid), .sym_idx(sym_idx), .last_sym(last_sym),
    .n_sym(n_sym), .n_pad(n_pad), .busy(busy), .done(done), .rate_err(rate_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_pkt(input string name, input logic [7:0] rate, input logic [15:0] len,
                         input int exp_n, input int exp_pad, input bit exp_err,
                         input bit toggle_ready, input int freeze_at, input int restart_at,
                         input int reset_at);
    int xfers = 0, dones = 0, errs = 0, valids = 0, cyc = 0, freeze_left = 0;
    bit finished = 0, froze = 0, restarted = 0, aborted = 0;
    pkt_rate  = rate;
    pkt_len   = len;
    start     = 1'b1;
    enable    = 1'b1;
    sym_ready = 1'b1;
    tick();
    start    = 1'b0;
    pkt_rate = 8'h0C;
    pkt_len  = 16'd7;
    chk($sformatf("%s.busy_after_start", name), busy, 1);
    while (!finished && cyc < 2000) begin
      sym_ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
      if (freeze_at >= 0 && !froze && sym_valid && xfers == freeze_at) begin
        freeze_left = 5;
        froze = 1;
      end
      enable = (freeze_left == 0);
      if (freeze_left > 0) freeze_left--;
      if (restart_at >= 0 && !restarted && sym_valid && xfers == restart_at) begin
        start    = 1'b1;
        pkt_rate = 8'h0B;
        pkt_len  = 16'd0;
        restarted = 1;
      end
      if (reset_at >= 0 && sym_valid && sym_idx == reset_at) reset = 1'b1;
      @(negedge clock);
      if (sym_valid) begin
        valids++;
        chk($sformatf("%s.sym_idx", name), sym_idx, xfers);
        chk($sformatf("%s.last_sym", name), last_sym, (xfers == exp_n - 1));
      end
      if (done) dones++;
      if (rate_err) errs++;
      if (sym_valid && sym_ready && enable && !reset) xfers++;
      if (done || rate_err) finished = 1;
      if (reset) begin
        aborted = 1;
        finished = 1;
      end
      tick();
      start = 1'b0;
      reset = 1'b0;
      cyc++;
    end
    enable = 1'b1;
    chk($sformatf("%s.completed_in_budget", name), finished, 1);
    if (aborted) begin
      chk($sformatf("%s.busy_after_reset", name), busy, 0);
      chk($sformatf("%s.valid_after_reset", name), sym_valid, 0);
      chk($sformatf("%s.done_after_reset", name), done, 0);
      chk($sformatf("%s.done_pulses", name), dones, 0);
    end else if (exp_err) begin
      chk($sformatf("%s.rate_err_pulses", name), errs, 1);
      chk($sformatf("%s.valid_cycles", name), valids, 0);
      chk($sformatf("%s.busy_end", name), busy, 0);
      chk($sformatf("%s.done_pulses", name), dones, 0);
    end else begin
      chk($sformatf("%s.transfers", name), xfers, exp_n);
      chk($sformatf("%s.done_pulses", name), dones, 1);
      chk($sformatf("%s.rate_err_pulses", name), errs, 0);
      chk($sformatf("%s.n_sym", name), n_sym, exp_n);
      chk($sformatf("%s.n_pad", name), n_pad, exp_pad);
      chk($sformatf("%s.busy_end", name), busy, 0);
    end
    $display("[TB] pkt %s rate=%02h len=%0d transfers=%0d n_sym=%0d n_pad=%0d done=%0d rate_err=%0d",
             name, rate, len, xfers, n_sym, n_pad, dones, errs);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    start     = 1'b0;
    sym_ready = 1'b0;
    pkt_rate  = 8'h00;
    pkt_len   = 16'd0;
    tick();
    tick();
    @(negedge clock);
    chk("reset.sym_valid", sym_valid, 0);
    chk("reset.sym_idx", sym_idx, 0);
    chk("reset.last_sym", last_sym, 0);
    chk("reset.n_sym", n_sym, 0);
    chk("reset.n_pad", n_pad, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.rate_err", rate_err, 0);

    // Reset wins over a simultaneous start.
    start    = 1'b1;
    enable   = 1'b1;
    pkt_rate = 8'h0B;
    pkt_len  = 16'd100;
    tick();
    chk("reset_prio.busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;

    // A start presented while frozen is not accepted.
    enable = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    enable = 1'b1;
    chk("frozen_start.busy", busy, 0);
    $display("[TB] reset/priority/freeze-start checks done");

    run_pkt("6M_len100", 8'h0B, 16'd100, 35, 18, 0, 0, -1, -1, -1);
    run_pkt("54M_len1500_toggle", 8'h0C, 16'd1500, 56, 74, 0, 1, -1, -1, -1);
    run_pkt("6M_len0", 8'h0B, 16'd0, 1, 2, 0, 0, -1, -1, -1);
    run_pkt("54M_len4095", 8'h0C, 16'd4095, 152, 50, 0, 0, -1, -1, -1);
`ifdef TX_SCHED_HT_EN
    run_pkt("HT_MCS7_len0", 8'h87, 16'd0, 1, 238, 0, 0, -1, -1, -1);
    run_pkt("HT_MCS0_len5000", 8'h80, 16'd5000, 1540, 18, 0, 0, -1, -1, -1);
`else
    run_pkt("HT_MCS0_disabled", 8'h80, 16'd100, 0, 0, 1, 0, -1, -1, -1);
`endif
    run_pkt("rate_00", 8'h00, 16'd100, 0, 0, 1, 0, -1, -1, -1);
    run_pkt("nonHT_len5000", 8'h0B, 16'd5000, 0, 0, 1, 0, -1, -1, -1);
    run_pkt("reset_at_idx10", 8'h0B, 16'd100, 35, 18, 0, 0, -1, -1, 10);
    run_pkt("restart_and_freeze", 8'h0B, 16'd100, 35, 18, 0, 1, 7, 3, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
